// File: rtl/bias_pkg.sv
// Shared constants and FSM state type for the bias-add scheduler.
package bias_pkg;

  localparam int LANE_W = 18;
  localparam int SUM_W  = 19;

  localparam logic signed [LANE_W-1:0] SAT_MAX = 18'sh1FFFF;
  localparam logic signed [LANE_W-1:0] SAT_MIN = 18'sh20000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bias_lane_add.sv
// One 18-bit lane: sign-extended add of data and bias into 19 bits, then fit to 18.
// BIAS_SAT_EN selects saturation; otherwise the sum wraps to its low 18 bits.
module bias_lane_add
  import bias_pkg::*;
(
  input  logic signed [LANE_W-1:0] data_i,
  input  logic signed [LANE_W-1:0] bias_i,
  output logic signed [LANE_W-1:0] sum_o
);

  logic signed [SUM_W-1:0] sum_w;

  function automatic logic signed [LANE_W-1:0] fit_lane(input logic signed [SUM_W-1:0] s);
`ifdef BIAS_SAT_EN
    // The two top bits disagree exactly when the 19-bit sum is outside 18-bit range.
    if (s[SUM_W-1] != s[SUM_W-2]) begin
      return s[SUM_W-1] ? SAT_MIN : SAT_MAX;
    end
    return s[LANE_W-1:0];
`else
    return s[LANE_W-1:0];
`endif
  endfunction

  assign sum_w = {data_i[LANE_W-1], data_i} + {bias_i[LANE_W-1], bias_i};
  assign sum_o = fit_lane(sum_w);

endmodule

// File: rtl/bias_add_sched.sv
// Adds a per-group constant bias to a stream of adder-tree rows, walking N_GROUPS
// groups of cfg_pixels beats per pass. Lane arithmetic honours BIAS_SAT_EN.
module bias_add_sched
  import bias_pkg::*;
#(
  parameter int N_adder_tree = 16,
  parameter int N_GROUPS     = 4,
  localparam int GW          = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  localparam int ROW_W       = N_adder_tree * LANE_W
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [15:0]                  cfg_pixels,
  input  logic [N_GROUPS*ROW_W-1:0]    bias_bank,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROW_W-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROW_W-1:0]             out_data,
  output logic [GW-1:0]                group_idx,
  output logic                         busy,
  output logic                         done
);

  state_e            state_q, state_d;
  logic [15:0]       pix_q, pix_d;
  logic [15:0]       npix_q, npix_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic              out_valid_q, out_valid_d;
  logic [ROW_W-1:0]  out_data_q, out_data_d;
  logic [ROW_W-1:0]  bias_sel;
  logic [ROW_W-1:0]  sum_row;
  logic              accept, last_pix, last_grp;

  assign bias_sel = bias_bank[int'(grp_q)*ROW_W +: ROW_W];

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_lane_add u_lane (
      .data_i (in_data[i*LANE_W +: LANE_W]),
      .bias_i (bias_sel[i*LANE_W +: LANE_W]),
      .sum_o  (sum_row[i*LANE_W +: LANE_W])
    );
  end

  // A new beat may enter whenever the output register is free or being drained this cycle.
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_pix = (pix_q == npix_q - 16'd1);
  assign last_grp = (grp_q == GW'(N_GROUPS - 1));

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    npix_d      = npix_q;
    grp_d       = grp_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          npix_d  = (cfg_pixels == 16'd0) ? 16'd1 : cfg_pixels;
          pix_d   = 16'd0;
          grp_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (last_pix) begin
            pix_d = 16'd0;
            if (last_grp) begin
              grp_d   = '0;
              state_d = DRAIN;
            end else begin
              grp_d = grp_q + 1'b1;
            end
          end else begin
            pix_d = pix_q + 16'd1;
          end
        end
      end
      DRAIN: begin
        if (!out_valid_q || out_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sum_row;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pix_q       <= 16'd0;
      npix_q      <= 16'd1;
      grp_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      npix_q      <= npix_d;
      grp_q       <= grp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign group_idx = grp_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_bias_add_sched.sv
// Directed bench for bias_add_sched (4 lanes, 2 groups) with a transaction-level reference model.
module tb_bias_add_sched;

  localparam int N  = 4;
  localparam int G  = 2;
  localparam int LW = 18;
  localparam int RW = N * LW;

`ifdef BIAS_SAT_EN
  localparam logic [17:0] OVF_POS = 18'h1FFFF;
  localparam logic [17:0] OVF_NEG = 18'h20000;
`else
  localparam logic [17:0] OVF_POS = 18'h20000;
  localparam logic [17:0] OVF_NEG = 18'h1FFFF;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   cfg_pixels = 16'd0;
  logic [G*RW-1:0] bias_bank = '0;
  logic          in_valid = 1'b0;
  logic [RW-1:0] in_data = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, busy, done;
  logic [RW-1:0] out_data;
  logic [0:0]    group_idx;

  always #5 clk = ~clk;

  bias_add_sched #(.N_adder_tree(N), .N_GROUPS(G)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_pixels(cfg_pixels), .bias_bank(bias_bank),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .group_idx(group_idx), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference arithmetic: signed integer sum, optionally clamped, low 18 bits kept.
  function automatic logic [LW-1:0] lane_ref(input logic [LW-1:0] a, input logic [LW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef BIAS_SAT_EN
    if (s > 131071)  s = 131071;
    if (s < -131072) s = -131072;
`endif
    return LW'(s);
  endfunction

  function automatic logic [RW-1:0] row_ref(input logic [RW-1:0] d, input int g);
    logic [RW-1:0] r;
    for (int i = 0; i < N; i++)
      r[i*LW +: LW] = lane_ref(d[i*LW +: LW], bias_bank[g*RW + i*LW +: LW]);
    return r;
  endfunction

  function automatic logic [RW-1:0] mkrow(input logic [17:0] a, input logic [17:0] b,
                                          input logic [17:0] c, input logic [17:0] d);
    return {d, c, b, a};
  endfunction

  // Pass-level model: beats taken so far decide the group; one output slot; drain then pulse.
  bit            m_active, m_drain, m_done, m_ov;
  int            m_taken, m_pix, m_total;
  logic [RW-1:0] m_od;
  bit            exp_rdy, acc;
  int            exp_g;

  always @(negedge clk) begin
    if (rst) begin
      m_active = 0; m_drain = 0; m_done = 0; m_ov = 0;
      m_taken = 0; m_pix = 1; m_total = 0; m_od = '0;
    end
    exp_rdy = m_active && (!m_ov || out_ready);
    exp_g   = m_active ? (m_taken / m_pix) : 0;
    chk("in_ready",  RW'(in_ready),  RW'(exp_rdy));
    chk("out_valid", RW'(out_valid), RW'(m_ov));
    chk("out_data",  out_data,       m_od);
    chk("group_idx", RW'(group_idx), RW'(exp_g));
    chk("busy",      RW'(busy),      RW'(m_active || m_drain));
    chk("done",      RW'(done),      RW'(m_done));
    if (done) done_cnt++;
    if (!rst) begin
      acc = exp_rdy && in_valid;
      if (m_done) begin
        m_done = 0;
      end else if (m_drain) begin
        if (!m_ov || out_ready) begin
          m_drain = 0;
          m_done  = 1;
        end
      end else if (!m_active && start) begin
        m_active = 1;
        m_taken  = 0;
        m_pix    = (cfg_pixels == 16'd0) ? 1 : int'(cfg_pixels);
        m_total  = m_pix * G;
      end
      if (acc) begin
        m_od = row_ref(in_data, exp_g);
        m_ov = 1;
        m_taken++;
        if (m_taken == m_total) begin
          m_active = 0;
          m_drain  = 1;
        end
      end else if (out_ready) begin
        m_ov = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bias(input int g, input int lane, input logic [17:0] v);
    bias_bank[g*RW + lane*LW +: LW] = v;
  endtask

  task automatic start_pass(input logic [15:0] pixels);
    bit idle = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (!busy && !done) begin idle = 1; break; end
    end
    chk("reach_idle", RW'(idle), RW'(1));
    tick();
    start = 1'b1;
    cfg_pixels = pixels;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [RW-1:0] d, output logic [0:0] grp_seen);
    bit got = 0;
    in_valid = 1'b1;
    in_data  = d;
    grp_seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) begin got = 1; grp_seen = group_idx; break; end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("beat_accepted", RW'(got), RW'(1));
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
    chk("done_seen", RW'(got), RW'(1));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [0:0] gs;
    int dc0;
    logic [RW-1:0] cap;
    logic [0:0] seq_exp [6];
    seq_exp = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    repeat (2) tick();
    chk("rst_out_valid", RW'(out_valid), '0);
    chk("rst_out_data",  out_data,       '0);
    chk("rst_in_ready",  RW'(in_ready),  '0);
    chk("rst_busy",      RW'(busy),      '0);
    rst = 1'b0;
    tick();

    // Basic add, one pixel per group.
    set_bias(0, 0, 18'h0095C);
    set_bias(1, 0, 18'h00010);
    start_pass(16'd1);
    send(mkrow(18'h00001, 0, 0, 0), gs);
    chk("basic_valid", RW'(out_valid), RW'(1));
    chk("basic_lane0", RW'(out_data[17:0]), RW'(18'h0095D));
    send(mkrow(18'h00005, 0, 0, 0), gs);
    chk("grp1_lane0", RW'(out_data[17:0]), RW'(18'h00015));
    dc0 = done_cnt;
    wait_done();
    repeat (3) tick();
    chk("basic_done_once", RW'(done_cnt - dc0), RW'(1));

    // Negative bias and both overflow directions; cfg_pixels=0 acts as 1.
    set_bias(0, 0, 18'h00000);
    set_bias(0, 1, 18'h3FF98);
    set_bias(0, 2, 18'h00001);
    set_bias(0, 3, 18'h3FFFF);
    set_bias(1, 1, 18'h00007);
    start_pass(16'd0);
    send(mkrow(18'h00000, 18'h00010, 18'h1FFFF, 18'h20000), gs);
    chk("neg_bias",   RW'(out_data[35:18]), RW'(18'h3FFA8));
    chk("ovf_pos",    RW'(out_data[53:36]), RW'(OVF_POS));
    chk("ovf_neg",    RW'(out_data[71:54]), RW'(OVF_NEG));
    chk("zero_cfg_grp", RW'(group_idx), RW'(1));
    send(mkrow(18'h00003, 18'h00002, 18'h00001, 18'h3FFFF), gs);
    chk("grp1_lane1", RW'(out_data[35:18]), RW'(18'h00009));
    wait_done();

    // Group sequencing: 3 pixels x 2 groups, back to back.
    start_pass(16'd3);
    for (int i = 0; i < 6; i++) begin
      send(mkrow(18'(i + 1), 18'(2 * i), 18'h3FFF0, 18'(100 + i)), gs);
      chk("seq_grp", RW'(gs), RW'(seq_exp[i]));
    end
    chk("seq_done_before", RW'(done), RW'(0));
    tick();
    chk("seq_done_after", RW'(done), RW'(1));
    tick();
    chk("seq_idle_busy", RW'(busy), RW'(0));

    // Backpressure: output stalls five cycles with a beat waiting.
    start_pass(16'd2);
    out_ready = 1'b0;
    send(mkrow(18'h00011, 18'h00022, 18'h00033, 18'h00044), gs);
    in_valid = 1'b1;
    in_data  = mkrow(18'h00100, 18'h00200, 18'h00300, 18'h00400);
    cap = out_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", out_data, cap);
      chk("bp_in_ready",  RW'(in_ready), RW'(0));
      chk("bp_valid",     RW'(out_valid), RW'(1));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", RW'(in_ready), RW'(1));
    tick();
    in_valid = 1'b0;
    chk("bp_release_lane0", RW'(out_data[17:0]), RW'(18'h00100));
    send(mkrow(18'h00001, 0, 0, 0), gs);
    send(mkrow(18'h00002, 0, 0, 0), gs);
    wait_done();

    // Reset mid-pass after two beats; the pass is abandoned without a done pulse.
    start_pass(16'd3);
    send(mkrow(18'h00001, 18'h00001, 18'h00001, 18'h00001), gs);
    send(mkrow(18'h00002, 18'h00002, 18'h00002, 18'h00002), gs);
    in_valid = 1'b1;
    in_data  = mkrow(18'h00003, 18'h00003, 18'h00003, 18'h00003);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", RW'(out_valid), '0);
    chk("mid_rst_data",  out_data, '0);
    chk("mid_rst_grp",   RW'(group_idx), '0);
    chk("mid_rst_busy",  RW'(busy), '0);
    chk("mid_rst_ready", RW'(in_ready), '0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    dc0 = done_cnt;
    repeat (4) tick();
    chk("mid_rst_no_done", RW'(done_cnt - dc0), '0);
    start_pass(16'd3);
    for (int i = 0; i < 6; i++) begin
      send(mkrow(18'(7 * i), 18'h20000, 18'h1FFFF, 18'(i)), gs);
      chk("restart_grp", RW'(gs), RW'(seq_exp[i]));
    end
    wait_done();

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bias_add_sched.md
BIAS_ADD_SCHED -- requirements
Module: bias_add_sched

Interface
REQ-001 SHALL have parameter N_adder_tree, default 16: number of parallel 18-bit lanes.
REQ-002 SHALL have parameter N_GROUPS, default 4: number of bias groups (output-channel tiles) per layer.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin a layer pass (pulse).
REQ-006 SHALL have port cfg_pixels, input, 16: beats per group, sampled on an accepted start.
REQ-007 SHALL have port bias_bank, input, N_GROUPS*N_adder_tree*18: concatenated constant bias groups, group g at bits [g*N_adder_tree*18 +: N_adder_tree*18].
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, N_adder_tree*18): adder-tree results, two's complement per lane.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, N_adder_tree*18): biased results.
REQ-010 SHALL have port group_idx, output, $clog2(N_GROUPS): group currently applied.
REQ-011 SHALL have ports busy (output, 1) and done (output, 1): pass active; one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-013 IDLE->RUN SHALL occur on start=1 while in IDLE; start in any other state SHALL be ignored.
REQ-014 cfg_pixels=0 SHALL be treated as 1.
REQ-015 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-016 A beat SHALL be accepted when in_valid && in_ready.
REQ-017 Each lane i SHALL compute out = in_data lane i + bias lane i of group group_idx, sign-extended to 19 bits before the add.
REQ-018 The result SHALL be registered: latency exactly 1 cycle from acceptance to out_valid.
REQ-019 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 The pixel counter SHALL increment on each accepted beat.
REQ-021 On acceptance of beat cfg_pixels-1, the pixel counter SHALL clear and group_idx SHALL increment.
REQ-022 On acceptance of the last beat of group N_GROUPS-1, the FSM SHALL go to DRAIN and group_idx SHALL wrap to 0.
REQ-023 DRAIN->DONE SHALL occur when the output register empties (out_valid=0, or out_ready=1 on that cycle).
REQ-024 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-025 busy SHALL be 1 in RUN and DRAIN and 0 otherwise.

Reset
REQ-026 Asserting rst SHALL immediately force: state IDLE, out_valid=0, out_data=0, group_idx=0, pixel counter=0, done=0, busy=0, in_ready=0.
REQ-027 Reset mid-pass SHALL discard any in-flight beat; no done pulse SHALL follow.

Configuration
REQ-028 With BIAS_SAT_EN defined, each 19-bit lane sum SHALL saturate to 18 bits (max 18'h1FFFF, min 18'h20000).
REQ-029 Without BIAS_SAT_EN, each lane SHALL keep the low 18 bits (wrap).

Structure
REQ-030 Shared package bias_pkg SHALL hold: lane width 18, sum width 19, saturation limits, FSM state enum.
REQ-031 A single sub-module bias_lane_add SHALL perform one lane's add and saturation, instantiated N_adder_tree times.
REQ-032 The FSM, counters and output register SHALL reside in the top module.

Verification
REQ-033 Basic add: start, cfg_pixels=1, N_GROUPS=1, lane0 in=18'h00001, bias 18'h0095C -> next cycle out_valid=1, lane0=18'h0095D; then done pulses once.
REQ-034 Negative bias: lane in=18'h00010, bias 18'h3FF98 (-104) -> lane out=18'h3FFA8 (-88).
REQ-035 Overflow: in=18'h1FFFF, bias=18'h00001 -> out 18'h1FFFF with BIAS_SAT_EN; 18'h20000 without.
REQ-036 Group sequencing: N_GROUPS=2, cfg_pixels=3, 6 back-to-back beats -> group_idx 0,0,0,1,1,1 per beat; done exactly 1 cycle after the 6th output transfers.
REQ-037 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data stable and in_ready=0; first beat after release is accepted in the same cycle out_ready rises.
REQ-038 Reset mid-run: assert rst after beat 2 of 6 -> all outputs zero immediately; a new start restarts at group 0 and pixel 0.
